// File: rtl/rdma_flow_mc.sv
// rtl/rdma_flow_mc.sv - per-channel outstanding-request tracker with in-order ack retirement
// Optional spurious-ack reporting on err_valid/err_chan when RDMA_FLOW_ERR_EN is defined.
module rdma_flow_mc #(
    parameter int N_CHAN     = 64,
    parameter int N_OST      = 16,
    parameter int SSN_BITS   = 24,
    parameter int ACK_QDEPTH = 16,
    localparam int CHAN_BITS = $clog2(N_CHAN),
    localparam int OST_BITS  = $clog2(N_OST)
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 s_req_valid,
    output logic                 s_req_ready,
    input  logic [CHAN_BITS-1:0] s_req_chan,
    input  logic [SSN_BITS-1:0]  s_req_ssn,
    input  logic                 s_req_last,
    input  logic                 s_req_cmplt,
    output logic                 m_req_valid,
    input  logic                 m_req_ready,
    output logic [CHAN_BITS-1:0] m_req_chan,
    output logic [SSN_BITS-1:0]  m_req_ssn,
    output logic [OST_BITS-1:0]  m_req_offs,
    input  logic                 s_ack_valid,
    output logic                 s_ack_ready,
    input  logic [CHAN_BITS-1:0] s_ack_chan,
    output logic                 m_ack_valid,
    input  logic                 m_ack_ready,
    output logic [CHAN_BITS-1:0] m_ack_chan,
    output logic [SSN_BITS-1:0]  m_ack_ssn,
    output logic                 m_ack_cmplt
`ifdef RDMA_FLOW_ERR_EN
    ,
    output logic                 err_valid,
    output logic [CHAN_BITS-1:0] err_chan
`endif
);

    localparam int ENT_W   = SSN_BITS + 2;
    localparam int QE_W    = CHAN_BITS + SSN_BITS + 1;
    localparam int QA_BITS = (ACK_QDEPTH > 1) ? $clog2(ACK_QDEPTH) : 1;
    localparam int QC_BITS = $clog2(ACK_QDEPTH + 1);

    logic [OST_BITS:0]  head [N_CHAN];
    logic [OST_BITS:0]  tail [N_CHAN];
    logic [OST_BITS:0]  req_occ;
    logic [OST_BITS:0]  ack_occ;
    logic               req_fire;
    logic               ack_fire;
    logic               ack_live;
    logic               ack_hit;

    logic [ENT_W-1:0]   ram [N_CHAN*N_OST];
    logic [ENT_W-1:0]   rd_data;
    logic [CHAN_BITS-1:0] rd_chan;
    logic               rd_pend;

    logic [QE_W-1:0]    q_mem [ACK_QDEPTH];
    logic [QA_BITS-1:0] q_wptr;
    logic [QA_BITS-1:0] q_rptr;
    logic [QC_BITS-1:0] q_count;
    logic [QC_BITS:0]   q_fill;
    logic               q_push;
    logic               q_pop;

    assign req_occ  = head[s_req_chan] - tail[s_req_chan];
    assign ack_occ  = head[s_ack_chan] - tail[s_ack_chan];

    // Full check uses registered occupancy only, so a same-cycle ack never frees the slot being written.
    assign s_req_ready = aresetn && m_req_ready && (req_occ < (OST_BITS+1)'(N_OST));
    assign req_fire    = s_req_valid && s_req_ready;
    assign m_req_valid = req_fire;
    assign m_req_chan  = s_req_chan;
    assign m_req_ssn   = s_req_ssn;
    assign m_req_offs  = head[s_req_chan][OST_BITS-1:0];

    // The pending RAM read is counted so its push always finds room.
    assign q_fill      = {1'b0, q_count} + (QC_BITS+1)'(rd_pend);
    assign s_ack_ready = aresetn && (q_fill <= (QC_BITS+1)'(ACK_QDEPTH - 2));
    assign ack_fire    = s_ack_valid && s_ack_ready;
    assign ack_live    = (ack_occ != '0);
    assign ack_hit     = ack_fire && ack_live;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < N_CHAN; i++) begin
                head[i] <= '0;
                tail[i] <= '0;
            end
            rd_pend <= 1'b0;
        end else begin
            if (req_fire)
                head[s_req_chan] <= head[s_req_chan] + 1'b1;
            if (ack_hit)
                tail[s_ack_chan] <= tail[s_ack_chan] + 1'b1;
            rd_pend <= ack_hit;
        end
    end

    always_ff @(posedge aclk) begin
        if (req_fire)
            ram[{s_req_chan, head[s_req_chan][OST_BITS-1:0]}] <= {s_req_cmplt, s_req_last, s_req_ssn};
        if (ack_hit) begin
            rd_data <= ram[{s_ack_chan, tail[s_ack_chan][OST_BITS-1:0]}];
            rd_chan <= s_ack_chan;
        end
    end

    // Only entries that closed a message (last=1) reach the user.
    assign q_push = rd_pend && rd_data[SSN_BITS];
    assign m_ack_valid = (q_count != '0);
    assign q_pop  = m_ack_valid && m_ack_ready;
    assign {m_ack_chan, m_ack_ssn, m_ack_cmplt} = q_mem[q_rptr];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            q_wptr  <= '0;
            q_rptr  <= '0;
            q_count <= '0;
        end else begin
            if (q_push)
                q_wptr <= (q_wptr == QA_BITS'(ACK_QDEPTH - 1)) ? '0 : q_wptr + 1'b1;
            if (q_pop)
                q_rptr <= (q_rptr == QA_BITS'(ACK_QDEPTH - 1)) ? '0 : q_rptr + 1'b1;
            case ({q_push, q_pop})
                2'b10:   q_count <= q_count + 1'b1;
                2'b01:   q_count <= q_count - 1'b1;
                default: q_count <= q_count;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (q_push)
            q_mem[q_wptr] <= {rd_chan, rd_data[SSN_BITS-1:0], rd_data[SSN_BITS+1]};
    end

`ifdef RDMA_FLOW_ERR_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_valid <= 1'b0;
            err_chan  <= '0;
        end else begin
            err_valid <= ack_fire && !ack_live;
            err_chan  <= s_ack_chan;
        end
    end
`endif

endmodule

// File: tb/tb_rdma_flow_mc.sv
// tb/tb_rdma_flow_mc.sv - self-checking bench for rdma_flow_mc against a queue-based flow model
module tb_rdma_flow_mc;
    localparam int NC = 64;
    localparam int NO = 16;
    localparam int SB = 24;
    localparam int QD = 16;
    localparam int CB = 6;
    localparam int OB = 4;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          s_req_valid, s_req_ready, s_req_last, s_req_cmplt;
    logic [CB-1:0] s_req_chan;
    logic [SB-1:0] s_req_ssn;
    logic          m_req_valid, m_req_ready;
    logic [CB-1:0] m_req_chan;
    logic [SB-1:0] m_req_ssn;
    logic [OB-1:0] m_req_offs;
    logic          s_ack_valid, s_ack_ready;
    logic [CB-1:0] s_ack_chan;
    logic          m_ack_valid, m_ack_ready, m_ack_cmplt;
    logic [CB-1:0] m_ack_chan;
    logic [SB-1:0] m_ack_ssn;
`ifdef RDMA_FLOW_ERR_EN
    logic          err_valid;
    logic [CB-1:0] err_chan;
`endif

    always #5 aclk = ~aclk;

    rdma_flow_mc dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_chan(s_req_chan),
        .s_req_ssn(s_req_ssn), .s_req_last(s_req_last), .s_req_cmplt(s_req_cmplt),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_chan(m_req_chan),
        .m_req_ssn(m_req_ssn), .m_req_offs(m_req_offs),
        .s_ack_valid(s_ack_valid), .s_ack_ready(s_ack_ready), .s_ack_chan(s_ack_chan),
        .m_ack_valid(m_ack_valid), .m_ack_ready(m_ack_ready), .m_ack_chan(m_ack_chan),
        .m_ack_ssn(m_ack_ssn), .m_ack_cmplt(m_ack_cmplt)
`ifdef RDMA_FLOW_ERR_EN
        , .err_valid(err_valid), .err_chan(err_chan)
`endif
    );

    typedef struct { logic [SB-1:0] ssn; logic last; logic cmplt; } ent_t;
    typedef struct { logic [CB-1:0] chan; logic [SB-1:0] ssn; logic cmplt; int vis; } ack_t;

    ent_t          chq [NC][$];
    int            head_cnt [NC];
    ack_t          exp_q [$];
    bit            inflight_nl, exp_err;
    logic [CB-1:0] exp_err_chan;
    int            cyc;
    bit            f_req, f_ack, f_pop;
    int            n_chk, n_fail, n_pops;
    logic [CB-1:0] pop_chan;
    logic [SB-1:0] pop_ssn;
    logic          pop_cmplt;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic model_reset();
        foreach (chq[i]) begin
            chq[i].delete();
            head_cnt[i] = 0;
        end
        exp_q.delete();
        inflight_nl = 0;
        exp_err = 0;
    endtask

    task automatic set_idle();
        s_req_valid = 0; s_req_chan = '0; s_req_ssn = '0; s_req_last = 0; s_req_cmplt = 0;
        s_ack_valid = 0; s_ack_chan = '0;
        m_req_ready = 1; m_ack_ready = 1;
    endtask

    task automatic set_req(input int ch, input int ssn, input bit last, input bit cmplt);
        s_req_valid = 1; s_req_chan = CB'(ch); s_req_ssn = SB'(ssn);
        s_req_last = last; s_req_cmplt = cmplt;
    endtask

    // Inputs are stable here; compare every output against the model.
    task automatic settle_check();
        bit rq, ar, mv;
        int fill;
        #1;
        rq   = aresetn && m_req_ready && (chq[s_req_chan].size() < NO);
        fill = exp_q.size() + int'(inflight_nl);
        ar   = aresetn && (fill <= QD - 2);
        mv   = (exp_q.size() > 0) && (exp_q[0].vis <= cyc);
        chk("s_req_ready", s_req_ready, rq);
        chk("m_req_valid", m_req_valid, s_req_valid && rq);
        if (s_req_valid && rq) begin
            chk("m_req_chan", m_req_chan, s_req_chan);
            chk("m_req_ssn", m_req_ssn, s_req_ssn);
            chk("m_req_offs", m_req_offs, head_cnt[s_req_chan] % NO);
        end
        chk("s_ack_ready", s_ack_ready, ar);
        chk("m_ack_valid", m_ack_valid, mv);
        if (mv) begin
            chk("m_ack_chan", m_ack_chan, exp_q[0].chan);
            chk("m_ack_ssn", m_ack_ssn, exp_q[0].ssn);
            chk("m_ack_cmplt", m_ack_cmplt, exp_q[0].cmplt);
        end
`ifdef RDMA_FLOW_ERR_EN
        chk("err_valid", err_valid, exp_err);
        if (exp_err)
            chk("err_chan", err_chan, exp_err_chan);
`endif
        f_req = s_req_valid && rq;
        f_ack = s_ack_valid && ar;
        f_pop = mv && m_ack_ready;
        if (m_ack_valid && m_ack_ready) begin
            n_pops++;
            pop_chan = m_ack_chan; pop_ssn = m_ack_ssn; pop_cmplt = m_ack_cmplt;
        end
    endtask

    task automatic advance();
        ent_t e;
        @(posedge aclk);
        cyc++;
        inflight_nl = 0;
        exp_err = 0;
        if (f_pop)
            void'(exp_q.pop_front());
        if (f_ack) begin
            if (chq[s_ack_chan].size() == 0) begin
                exp_err = 1;
                exp_err_chan = s_ack_chan;
            end else begin
                e = chq[s_ack_chan].pop_front();
                if (e.last)
                    exp_q.push_back('{chan: s_ack_chan, ssn: e.ssn, cmplt: e.cmplt, vis: cyc + 1});
                else
                    inflight_nl = 1;
            end
        end
        if (f_req) begin
            chq[s_req_chan].push_back('{ssn: s_req_ssn, last: s_req_last, cmplt: s_req_cmplt});
            head_cnt[s_req_chan]++;
        end
        #1;
    endtask

    task automatic step();
        settle_check();
        advance();
    endtask

    task automatic do_reset();
        set_idle();
        aresetn = 0;
        model_reset();
        settle_check();
        chk("rst_s_req_ready", s_req_ready, 0);
        chk("rst_s_ack_ready", s_ack_ready, 0);
        chk("rst_m_ack_valid", m_ack_valid, 0);
        advance();
        step();
        aresetn = 1;
    endtask

    initial begin
        int p0, nacc;
        n_chk = 0; n_fail = 0; n_pops = 0; cyc = 0;
        set_idle();
        model_reset();
        do_reset();
        settle_check();
        chk("post_rst_s_req_ready", s_req_ready, 1);
        chk("post_rst_s_ack_ready", s_ack_ready, 1);
        advance();

        // Fill chan 5, then the 17th request is refused.
        for (int i = 0; i < 16; i++) begin
            set_req(5, 500 + i, 1, i[0]);
            settle_check();
            chk("fill5_offs", m_req_offs, i);
            advance();
        end
        set_req(5, 516, 1, 0);
        settle_check();
        chk("fill5_full", s_req_ready, 0);
        advance();

        // Ack and request together on full chan 5.
        p0 = n_pops;
        s_ack_valid = 1; s_ack_chan = 5;
        settle_check();
        chk("same_cyc_req_blocked", s_req_ready, 0);
        chk("same_cyc_ack_ready", s_ack_ready, 1);
        advance();
        s_ack_valid = 0;
        settle_check();
        chk("after_ack_req_valid", m_req_valid, 1);
        chk("after_ack_offs", m_req_offs, 0);
        advance();
        set_idle();
        repeat (3) step();
        chk("ack5_pops", n_pops - p0, 1);
        chk("ack5_ssn", pop_ssn, 500);
        chk("ack5_chan", pop_chan, 5);

        // last=0 entry is retired silently.
        p0 = n_pops;
        set_req(3, 100, 0, 0); step();
        set_req(3, 101, 1, 1); step();
        set_idle();
        s_ack_valid = 1; s_ack_chan = 3; step(); step();
        set_idle();
        repeat (4) step();
        chk("chan3_pops", n_pops - p0, 1);
        chk("chan3_chan", pop_chan, 3);
        chk("chan3_ssn", pop_ssn, 101);
        chk("chan3_cmplt", pop_cmplt, 1);

        // Ack queue backpressure.
        for (int i = 0; i < 32; i++) begin
            set_req(10 + i / 16, 1000 + i, 1, i[1]);
            step();
        end
        set_idle();
        m_ack_ready = 0;
        nacc = 0;
        for (int i = 0; i < 20; i++) begin
            s_ack_valid = 1; s_ack_chan = CB'(10 + i % 2);
            settle_check();
            if (s_ack_ready) nacc++;
            advance();
        end
        s_ack_valid = 0;
        repeat (3) step();
        chk("bp_accepted", nacc, 15);
        chk("bp_hold_valid", m_ack_valid, 1);
        p0 = n_pops;
        m_ack_ready = 1;
        repeat (20) step();
        chk("bp_drained", n_pops - p0, 15);
        chk("bp_empty", m_ack_valid, 0);

        // Spurious ack on empty chan 9.
        p0 = n_pops;
        s_ack_valid = 1; s_ack_chan = 9;
        settle_check();
        chk("spur_ack_ready", s_ack_ready, 1);
        advance();
        s_ack_valid = 0;
        settle_check();
`ifdef RDMA_FLOW_ERR_EN
        chk("spur_err_valid", err_valid, 1);
        chk("spur_err_chan", err_chan, 9);
`endif
        advance();
        repeat (3) step();
        chk("spur_no_ack", n_pops - p0, 0);
        set_req(9, 900, 1, 0);
        settle_check();
        chk("spur_offs", m_req_offs, 0);
        advance();
        set_idle();

        // Reset with 7 outstanding on chan 2.
        for (int i = 0; i < 7; i++) begin
            set_req(2, 200 + i, 1, 0);
            step();
        end
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_req(2, 300 + i, 1, 1);
            settle_check();
            chk("rst2_offs", m_req_offs, i);
            advance();
        end
        set_req(2, 316, 1, 1);
        settle_check();
        chk("rst2_full", s_req_ready, 0);
        advance();

        // Randomized traffic on a few channels.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            s_req_valid = ($urandom_range(0, 9) < 6);
            s_req_chan  = CB'($urandom_range(0, 3));
            s_req_ssn   = SB'($urandom);
            s_req_last  = $urandom_range(0, 2) != 0;
            s_req_cmplt = $urandom_range(0, 1) != 0;
            m_req_ready = $urandom_range(0, 4) != 0;
            s_ack_valid = $urandom_range(0, 1) != 0;
            s_ack_chan  = CB'($urandom_range(0, 3));
            m_ack_ready = $urandom_range(0, 2) != 0;
            step();
        end
        set_idle();
        repeat (30) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rdma_flow_mc.md
RDMA_FLOW_MC -- requirements
Module: rdma_flow_mc

Interface
REQ-001 Parameter N_CHAN, default 64: number of independently tracked flows (channel = {rd, vfid, pid} flattened by the caller); power of 2, CHAN_BITS = log2(N_CHAN).
REQ-002 Parameter N_OST, default 16: maximum outstanding requests per channel; power of 2, OST_BITS = log2(N_OST).
REQ-003 Parameter SSN_BITS, default 24: sequence-number width.
REQ-004 Parameter ACK_QDEPTH, default 16: output ack queue depth; minimum 4.
REQ-005 aclk  in  1  single clock; all logic is rising-edge.
REQ-006 aresetn  in  1  asynchronous, active-low reset.
REQ-007 s_req_valid / s_req_ready  in / out  1 / 1  request handshake.
REQ-008 s_req_chan, s_req_ssn, s_req_last, s_req_cmplt  in  CHAN_BITS, SSN_BITS, 1, 1  request channel and bookkeeping fields.
REQ-009 m_req_valid / m_req_ready  out / in  1 / 1  forwarded-request handshake.
REQ-010 m_req_chan, m_req_ssn, m_req_offs  out  CHAN_BITS, SSN_BITS, OST_BITS  forwarded request; m_req_offs is the slot index.
REQ-011 s_ack_valid / s_ack_ready, s_ack_chan  in / out, in  1 / 1, CHAN_BITS  ack from the protocol engine.
REQ-012 m_ack_valid / m_ack_ready  out / in  1 / 1  user ack handshake.
REQ-013 m_ack_chan, m_ack_ssn, m_ack_cmplt  out  CHAN_BITS, SSN_BITS, 1  user ack fields.
REQ-014 err_valid, err_chan  out  1, CHAN_BITS  spurious-ack report; present only under RDMA_FLOW_ERR_EN.

Function
REQ-015 Per channel: head and tail pointers of OST_BITS+1 bits each; occupancy = head - tail, modulo 2^(OST_BITS+1).
REQ-016 Request acceptance: s_req_ready = m_req_ready AND occupancy(s_req_chan) < N_OST, evaluated on registered state; combinational path, zero latency.
REQ-017 m_req_valid = s_req_valid AND s_req_ready; m_req_chan / m_req_ssn pass through; m_req_offs = head[OST_BITS-1:0].
REQ-018 On request accept: write {cmplt, last, ssn} to slot {chan, head[OST_BITS-1:0]} of a 1W/1R RAM; head increments.
REQ-019 s_ack_ready = 1 when the ack queue holds at most ACK_QDEPTH-2 entries, counting the one in-flight RAM read.
REQ-020 On ack accept: read slot {chan, tail[OST_BITS-1:0]}; tail increments; data valid 1 cycle later.
REQ-021 Retired entry with last=1: push {chan, ssn, cmplt} to the ack queue. Entry with last=0: discarded silently.
REQ-022 Ack and request accepted in the same cycle, same or different channel: both serviced; same-channel occupancy unchanged.
REQ-023 A full channel blocks requests even when an ack for it arrives in the same cycle. This guarantees the RAM read and write addresses never collide.
REQ-024 Ack on a channel with occupancy 0: accepted and dropped; pointers unchanged; no RAM read; no queue push.
REQ-025 Pointer wrap-around at 2^(OST_BITS+1) is natural and needs no special handling.
REQ-026 Ack queue: FIFO, standard valid/ready; m_ack_* hold stable while m_ack_valid=1 and m_ack_ready=0.
REQ-027 Worst-case ack-to-m_ack_valid latency with an empty queue: 2 cycles.

Reset
REQ-028 Asynchronous assertion of aresetn=0 clears all head/tail pointers, the read-pending flag and the ack queue. m_ack_valid=0, err_valid=0.
REQ-029 Reset mid-operation discards all outstanding entries. After release, every channel behaves as empty; RAM contents are not cleared.
REQ-030 s_req_ready and s_ack_ready shall be 0 while aresetn=0.

Configuration
REQ-031 With macro RDMA_FLOW_ERR_EN defined: a REQ-024 ack drives err_valid=1 for exactly one cycle, in the cycle after the ack, with err_chan = the ack channel.
REQ-032 Without RDMA_FLOW_ERR_EN: the err ports and their logic are absent; spurious acks are still silently dropped.

Verification
REQ-033 Chan 5: 16 requests with last=1 and m_req_ready=1 -> 16 accepted with offs 0..15; the 17th sees s_req_ready=0.
REQ-034 Chan 5 full: send ack and request in the same cycle -> request blocked; next cycle request accepted with offs=0; m_ack ssn = first ssn.
REQ-035 Requests ssn 100 (last=0) and 101 (last=1, cmplt=1) on chan 3, then 2 acks -> exactly one m_ack: chan=3, ssn=101, cmplt=1.
REQ-036 m_ack_ready=0, 20 acks offered back-to-back on filled channels -> s_ack_ready drops after 14 pushes; no queue entry lost; release yields all entries in order.
REQ-037 Ack to empty chan 9 with RDMA_FLOW_ERR_EN -> err_valid pulse with err_chan=9; pointers unchanged. Without the macro -> no m_ack.
REQ-038 Reset asserted with 7 outstanding on chan 2 -> after release, 16 new requests are accepted on chan 2 starting at offs=0.
